// File: rtl/ifq.sv
// Instruction fetch queue: prefetches 16-byte lines from the icache into a small ring
// and hands out one instruction per consume. Define IFQ_BYPASS_EN to forward into an empty queue.
module ifq #(
  parameter int                W_DATA   = 32,
  parameter int                W_LINE   = 128,
  parameter int                W_DEPTH  = 2,
  parameter logic [W_DATA-1:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [W_DATA-1:0] icache_pcin,
  output logic              icache_ren,
  output logic              icache_abort,
  input  logic [W_LINE-1:0] icache_dout,
  input  logic              icache_dout_valid,
  input  logic              dsp_ren,
  input  logic              dsp_jmp_valid,
  input  logic [W_DATA-1:0] dsp_jmp_addr,
  output logic [W_DATA-1:0] dsp_dout,
  output logic [W_DATA-1:0] dsp_pcout,
  output logic              dsp_empty
);

  localparam int                 DEPTH    = 1 << W_DEPTH;
  localparam logic [W_DEPTH:0]   FULL_CNT = (W_DEPTH+1)'(DEPTH);
  localparam logic [W_DATA-1:0]  PC_BASE  = {RESET_PC[W_DATA-1:4], 4'b0};
  localparam logic [W_DATA-1:0]  LINE_B   = W_DATA'(16);

  typedef enum logic [1:0] {FETCH, WAIT, FULL} state_t;

  state_t              state, state_nxt;
  logic [W_LINE-1:0]   mem [DEPTH];
  logic [W_DEPTH-1:0]  wptr, rptr;
  logic [W_DEPTH:0]    cnt, cnt_nxt;
  logic [1:0]          offset, offset_nxt;
  logic                inflight, inf_nxt;
  logic [W_DATA-1:0]   fetch_pc, fetch_pc_nxt, head_pc, head_pc_nxt;
  logic [W_DATA-1:0]   jmp_line;
  logic [W_LINE-1:0]   line;
  logic [W_DATA-1:0]   word;
  logic                ren, wr, byp, empty_i, consume, pop;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^dsp_jmp_addr[1:0];
  assign jmp_line        = {dsp_jmp_addr[W_DATA-1:4], 4'b0};

  always_comb begin
    ren          = 1'b0;
    wr           = 1'b0;
    byp          = 1'b0;
    empty_i      = 1'b1;
    consume      = 1'b0;
    pop          = 1'b0;
    line         = mem[rptr];
    word         = '0;
    cnt_nxt      = cnt;
    inf_nxt      = inflight;
    offset_nxt   = offset;
    fetch_pc_nxt = fetch_pc;
    head_pc_nxt  = head_pc;
    state_nxt    = state;

    ren = reset && (state != FULL) && !dsp_jmp_valid;
    // Only a line we are actually waiting for is accepted; stray or post-reset returns are dropped.
    wr  = reset && icache_dout_valid && inflight && !dsp_jmp_valid;
`ifdef IFQ_BYPASS_EN
    byp = wr && (cnt == '0);
`else
    byp = 1'b0;
`endif
    if (byp) line = icache_dout;
    empty_i = (cnt == '0) && !byp;
    word    = line[W_DATA*int'(offset) +: W_DATA];
    consume = reset && dsp_ren && !empty_i && !dsp_jmp_valid;
    pop     = consume && (offset == 2'd3);

    cnt_nxt = cnt + {{W_DEPTH{1'b0}}, wr} - {{W_DEPTH{1'b0}}, pop};
    if (ren)     inf_nxt = 1'b1;
    else if (wr) inf_nxt = 1'b0;
    if (consume) offset_nxt = offset + 2'd1;
    if (ren)     fetch_pc_nxt = fetch_pc + LINE_B;
    if (pop)     head_pc_nxt  = head_pc + LINE_B;

    if (dsp_jmp_valid) begin
      cnt_nxt      = '0;
      inf_nxt      = 1'b0;
      offset_nxt   = dsp_jmp_addr[3:2];
      fetch_pc_nxt = jmp_line;
      head_pc_nxt  = jmp_line;
    end

    if ((cnt_nxt + {{W_DEPTH{1'b0}}, inf_nxt}) == FULL_CNT) state_nxt = FULL;
    else if (inf_nxt)                                        state_nxt = WAIT;
    else                                                     state_nxt = FETCH;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= FETCH;
      cnt      <= '0;
      wptr     <= '0;
      rptr     <= '0;
      offset   <= 2'd0;
      inflight <= 1'b0;
      fetch_pc <= PC_BASE;
      head_pc  <= PC_BASE;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      offset   <= offset_nxt;
      inflight <= inf_nxt;
      fetch_pc <= fetch_pc_nxt;
      head_pc  <= head_pc_nxt;
      if (dsp_jmp_valid) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr)  wptr <= wptr + W_DEPTH'(1);
        if (pop) rptr <= rptr + W_DEPTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= icache_dout;
  end

  assign icache_ren   = ren;
  assign icache_abort = reset && dsp_jmp_valid;
  assign icache_pcin  = reset ? fetch_pc : PC_BASE;
  assign dsp_empty    = !reset || empty_i;
  assign dsp_dout     = reset ? word : '0;
  assign dsp_pcout    = reset ? (head_pc + W_DATA'({offset, 2'b00}) + W_DATA'(4)) : '0;

endmodule

// File: tb/tb_ifq.sv
// Directed bench for ifq: a 1-cycle-latency icache model feeds the queue; each task
// drives one scenario and checks ports against hand-computed values.
module tb_ifq;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  icache_pcin;
  logic         icache_ren, icache_abort;
  logic [127:0] icache_dout;
  logic         icache_dout_valid;
  logic         dsp_ren, dsp_jmp_valid;
  logic [31:0]  dsp_jmp_addr;
  logic [31:0]  dsp_dout, dsp_pcout;
  logic         dsp_empty;

  logic         resp_valid = 1'b0;
  logic [31:0]  resp_addr  = 32'h0;
  logic         inj_valid  = 1'b0;
  int           total = 0;
  int           bad   = 0;

  always #5 clk = ~clk;

  ifq dut (
    .clk(clk), .reset(reset),
    .icache_pcin(icache_pcin), .icache_ren(icache_ren), .icache_abort(icache_abort),
    .icache_dout(icache_dout), .icache_dout_valid(icache_dout_valid),
    .dsp_ren(dsp_ren), .dsp_jmp_valid(dsp_jmp_valid), .dsp_jmp_addr(dsp_jmp_addr),
    .dsp_dout(dsp_dout), .dsp_pcout(dsp_pcout), .dsp_empty(dsp_empty)
  );

  // Line at 0 is the fixed pattern; any other line holds D000_0000 | (word address).
  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    if (a == 32'h0) return 128'h33332222_11110000_AAAA0001_BBBB0000;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = 32'hD000_0000 | (a + 32'(4*k));
    return l;
  endfunction

  always @(posedge clk) begin
    resp_valid <= icache_ren && !icache_abort;
    if (icache_ren) resp_addr <= icache_pcin;
  end
  assign icache_dout       = line_of(resp_addr);
  assign icache_dout_valid = resp_valid | inj_valid;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; dsp_jmp_valid = 1'b1; dsp_jmp_addr = 32'h48; dsp_ren = 1'b1;
    cyc(); cyc(); #1;
    total++; if (icache_ren !== 1'b0) begin bad++; $display("FAIL rst_ren got=%0h exp=0", icache_ren); end
    total++; if (icache_abort !== 1'b0) begin bad++; $display("FAIL rst_abort got=%0h exp=0", icache_abort); end
    total++; if (icache_pcin !== 32'h0) begin bad++; $display("FAIL rst_pcin got=%h exp=0", icache_pcin); end
    total++; if (dsp_empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%0h exp=1", dsp_empty); end
    total++; if (dsp_dout !== 32'h0) begin bad++; $display("FAIL rst_dout got=%h exp=0", dsp_dout); end
    total++; if (dsp_pcout !== 32'h0) begin bad++; $display("FAIL rst_pcout got=%h exp=0", dsp_pcout); end
    dsp_jmp_valid = 1'b0; dsp_ren = 1'b0;
  endtask

  task automatic test_fill();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h00, 32'h10, 32'h20, 32'h30};
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 0) reset = 1'b1;
      #1;
      total++; if (icache_ren !== 1'b1) begin bad++; $display("FAIL fill_ren%0d got=%0h exp=1", i, icache_ren); end
      total++; if (icache_pcin !== exp_pc[i]) begin bad++; $display("FAIL fill_pcin%0d got=%h exp=%h", i, icache_pcin, exp_pc[i]); end
      if (i == 2) begin
        total++; if (dsp_empty !== 1'b0) begin bad++; $display("FAIL fill_empty got=%0h exp=0", dsp_empty); end
        total++; if (dsp_dout !== 32'hBBBB0000) begin bad++; $display("FAIL fill_dout got=%h exp=BBBB0000", dsp_dout); end
      end
    end
    cyc(); #1;
    total++; if (icache_ren !== 1'b0) begin bad++; $display("FAIL fill_ren4 got=%0h exp=0", icache_ren); end
    cyc(); cyc(); #1;
    total++; if (icache_ren !== 1'b0) begin bad++; $display("FAIL fill_ren6 got=%0h exp=0", icache_ren); end
    total++; if (icache_pcin !== 32'h40) begin bad++; $display("FAIL fill_pcin6 got=%h exp=40", icache_pcin); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_d [4];
    logic [31:0] exp_p [4];
    exp_d = '{32'hBBBB0000, 32'hAAAA0001, 32'h11110000, 32'h33332222};
    exp_p = '{32'h4, 32'h8, 32'hC, 32'h10};
    for (int i = 0; i < 4; i++) begin
      cyc(); dsp_ren = 1'b1; #1;
      total++; if (dsp_dout !== exp_d[i]) begin bad++; $display("FAIL stream_dout%0d got=%h exp=%h", i, dsp_dout, exp_d[i]); end
      total++; if (dsp_pcout !== exp_p[i]) begin bad++; $display("FAIL stream_pc%0d got=%h exp=%h", i, dsp_pcout, exp_p[i]); end
      total++; if (icache_ren !== 1'b0) begin bad++; $display("FAIL stream_ren%0d got=%0h exp=0", i, icache_ren); end
    end
    cyc(); dsp_ren = 1'b0; #1;
    total++; if (icache_ren !== 1'b1) begin bad++; $display("FAIL stream_ren_after_pop got=%0h exp=1", icache_ren); end
    total++; if (icache_pcin !== 32'h40) begin bad++; $display("FAIL stream_pcin got=%h exp=40", icache_pcin); end
    total++; if (dsp_dout !== 32'hD0000010) begin bad++; $display("FAIL stream_next_dout got=%h exp=D0000010", dsp_dout); end
    total++; if (dsp_pcout !== 32'h14) begin bad++; $display("FAIL stream_next_pc got=%h exp=14", dsp_pcout); end
  endtask

  task automatic test_full_stall();
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      total++; if (icache_ren !== 1'b0) begin bad++; $display("FAIL full_ren%0d got=%0h exp=0", i, icache_ren); end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(); dsp_ren = 1'b1; #1;
      total++; if (icache_ren !== 1'b0) begin bad++; $display("FAIL full_cons_ren%0d got=%0h exp=0", i, icache_ren); end
      total++; if (dsp_dout !== 32'hD0000010 + 32'(4*i)) begin bad++; $display("FAIL full_dout%0d got=%h exp=%h", i, dsp_dout, 32'hD0000010 + 32'(4*i)); end
    end
    cyc(); dsp_ren = 1'b0; #1;
    total++; if (icache_ren !== 1'b1) begin bad++; $display("FAIL full_ren_after_pop got=%0h exp=1", icache_ren); end
    total++; if (icache_pcin !== 32'h50) begin bad++; $display("FAIL full_pcin got=%h exp=50", icache_pcin); end
    total++; if (dsp_dout !== 32'hD0000020) begin bad++; $display("FAIL full_head got=%h exp=D0000020", dsp_dout); end
  endtask

  task automatic test_jump_inflight();
    cyc(); dsp_jmp_valid = 1'b1; dsp_jmp_addr = 32'h48; #1;
    total++; if (icache_abort !== 1'b1) begin bad++; $display("FAIL jmp_abort got=%0h exp=1", icache_abort); end
    total++; if (icache_ren !== 1'b0) begin bad++; $display("FAIL jmp_ren got=%0h exp=0", icache_ren); end
    cyc(); dsp_jmp_valid = 1'b0; #1;
    total++; if (icache_ren !== 1'b1) begin bad++; $display("FAIL jmp_ren_next got=%0h exp=1", icache_ren); end
    total++; if (icache_pcin !== 32'h40) begin bad++; $display("FAIL jmp_pcin got=%h exp=40", icache_pcin); end
    total++; if (dsp_empty !== 1'b1) begin bad++; $display("FAIL jmp_flushed got=%0h exp=1", dsp_empty); end
    total++; if (icache_abort !== 1'b0) begin bad++; $display("FAIL jmp_abort_clr got=%0h exp=0", icache_abort); end
    cyc(); #1;
`ifdef IFQ_BYPASS_EN
    total++; if (dsp_empty !== 1'b0) begin bad++; $display("FAIL jmp_byp_empty got=%0h exp=0", dsp_empty); end
    total++; if (dsp_dout !== 32'hD0000048) begin bad++; $display("FAIL jmp_byp_dout got=%h exp=D0000048", dsp_dout); end
`else
    total++; if (dsp_empty !== 1'b1) begin bad++; $display("FAIL jmp_arrive_empty got=%0h exp=1", dsp_empty); end
`endif
    cyc(); #1;
    total++; if (dsp_empty !== 1'b0) begin bad++; $display("FAIL jmp_line_empty got=%0h exp=0", dsp_empty); end
    total++; if (dsp_dout !== 32'hD0000048) begin bad++; $display("FAIL jmp_dout got=%h exp=D0000048", dsp_dout); end
    total++; if (dsp_pcout !== 32'h4C) begin bad++; $display("FAIL jmp_pcout got=%h exp=4C", dsp_pcout); end
  endtask

  task automatic test_jump_consume();
    cyc(); #1;
    cyc(); dsp_jmp_valid = 1'b1; dsp_jmp_addr = 32'h104; dsp_ren = 1'b1; #1;
    total++; if (dsp_empty !== 1'b0) begin bad++; $display("FAIL jc_pre_empty got=%0h exp=0", dsp_empty); end
    total++; if (icache_abort !== 1'b1) begin bad++; $display("FAIL jc_abort got=%0h exp=1", icache_abort); end
    cyc(); dsp_jmp_valid = 1'b0; dsp_ren = 1'b0; #1;
    total++; if (dsp_empty !== 1'b1) begin bad++; $display("FAIL jc_count0 got=%0h exp=1", dsp_empty); end
    total++; if (icache_pcin !== 32'h100) begin bad++; $display("FAIL jc_pcin got=%h exp=100", icache_pcin); end
    cyc(); #1;
    cyc(); #1;
    total++; if (dsp_dout !== 32'hD0000104) begin bad++; $display("FAIL jc_dout got=%h exp=D0000104", dsp_dout); end
    total++; if (dsp_pcout !== 32'h108) begin bad++; $display("FAIL jc_pcout got=%h exp=108", dsp_pcout); end
  endtask

  task automatic test_bypass();
    cyc(); dsp_jmp_valid = 1'b1; dsp_jmp_addr = 32'h200; #1;
    cyc(); dsp_jmp_valid = 1'b0; #1;
    total++; if (icache_pcin !== 32'h200) begin bad++; $display("FAIL byp_pcin got=%h exp=200", icache_pcin); end
    total++; if (dsp_empty !== 1'b1) begin bad++; $display("FAIL byp_pre_empty got=%0h exp=1", dsp_empty); end
    cyc(); dsp_ren = 1'b1; #1;
`ifdef IFQ_BYPASS_EN
    total++; if (dsp_empty !== 1'b0) begin bad++; $display("FAIL byp_empty got=%0h exp=0", dsp_empty); end
    total++; if (dsp_dout !== 32'hD0000200) begin bad++; $display("FAIL byp_dout got=%h exp=D0000200", dsp_dout); end
    cyc(); #1;
    total++; if (dsp_dout !== 32'hD0000204) begin bad++; $display("FAIL byp_next_dout got=%h exp=D0000204", dsp_dout); end
    total++; if (dsp_pcout !== 32'h208) begin bad++; $display("FAIL byp_next_pc got=%h exp=208", dsp_pcout); end
`else
    total++; if (dsp_empty !== 1'b1) begin bad++; $display("FAIL byp_empty got=%0h exp=1", dsp_empty); end
    cyc(); #1;
    total++; if (dsp_dout !== 32'hD0000200) begin bad++; $display("FAIL byp_next_dout got=%h exp=D0000200", dsp_dout); end
    total++; if (dsp_pcout !== 32'h204) begin bad++; $display("FAIL byp_next_pc got=%h exp=204", dsp_pcout); end
`endif
  endtask

  task automatic test_reset_midflight();
    cyc(); dsp_ren = 1'b0; #1;
    cyc(); reset = 1'b0; #1;
    total++; if (icache_ren !== 1'b0) begin bad++; $display("FAIL mid_ren got=%0h exp=0", icache_ren); end
    total++; if (dsp_empty !== 1'b1) begin bad++; $display("FAIL mid_empty got=%0h exp=1", dsp_empty); end
    total++; if (dsp_pcout !== 32'h0) begin bad++; $display("FAIL mid_pcout got=%h exp=0", dsp_pcout); end
    cyc(); #1;
    cyc(); reset = 1'b1; inj_valid = 1'b1; #1;
    total++; if (icache_ren !== 1'b1) begin bad++; $display("FAIL mid_rel_ren got=%0h exp=1", icache_ren); end
    total++; if (icache_pcin !== 32'h0) begin bad++; $display("FAIL mid_rel_pcin got=%h exp=0", icache_pcin); end
    total++; if (dsp_empty !== 1'b1) begin bad++; $display("FAIL mid_stray_empty got=%0h exp=1", dsp_empty); end
    cyc(); inj_valid = 1'b0; #1;
    cyc(); #1;
    total++; if (dsp_empty !== 1'b0) begin bad++; $display("FAIL mid_line_empty got=%0h exp=0", dsp_empty); end
    total++; if (dsp_dout !== 32'hBBBB0000) begin bad++; $display("FAIL mid_dout got=%h exp=BBBB0000", dsp_dout); end
    total++; if (dsp_pcout !== 32'h4) begin bad++; $display("FAIL mid_pcout2 got=%h exp=4", dsp_pcout); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; dsp_ren = 1'b0; dsp_jmp_valid = 1'b0; dsp_jmp_addr = 32'h0;
    test_reset();
    test_fill();
    test_stream();
    test_full_stall();
    test_jump_inflight();
    test_jump_consume();
    test_bypass();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
